// File: rtl/inner_dot_acc_pipe.sv
// Three-stage signed dot-product engine: product registers, balanced adder tree,
// then group accumulation with bias, round-half-up requantisation, ReLU and saturation.
module inner_dot_acc_pipe #(
    parameter int N_TAPS  = 9,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic [N_TAPS*DATA_W-1:0]   data_bus,
    input  logic [N_TAPS*DATA_W-1:0]   weight_bus,
    input  logic [ACC_W-1:0]           bias,
    input  logic [SHIFT_W-1:0]         shift,
    input  logic                       relu_en,
    output logic                       out_vld,
    output logic [ACC_W-1:0]           ans,
    output logic [OUT_W-1:0]           q_out,
    output logic                       ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int LEVELS = $clog2(N_TAPS);
    localparam int TREE_W = PROD_W + LEVELS;
    localparam int EXT_W  = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] Q_MAX   = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Q_MIN   = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] RND_ONE = {{(EXT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]        Q_MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        Q_MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_r [N_TAPS];
    logic                     vld1_r, first1_r, last1_r;
    logic signed [ACC_W-1:0]  bias1_r;

    logic signed [TREE_W-1:0] tree_s, tree_r;
    logic                     vld2_r, first2_r, last2_r;
    logic signed [ACC_W-1:0]  bias2_r;

    logic signed [ACC_W-1:0]  acc_r, acc_next_s;
    logic                     sticky_r, sticky_next_s, acc_clamp_s;
    logic signed [EXT_W-1:0]  base_s, sum_s, rnd_s, r_s, r_relu_s;
    logic [OUT_W-1:0]         q_s;
    logic                     q_clamp_s;

    logic                     out_vld_r, ovf_r;
    logic [ACC_W-1:0]         ans_r;
    logic [OUT_W-1:0]         q_out_r;

    // Stage 1: per-tap products plus beat control and bias copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) prod_r[i] <= {PROD_W{1'b0}};
            vld1_r   <= 1'b0;
            first1_r <= 1'b0;
            last1_r  <= 1'b0;
            bias1_r  <= {ACC_W{1'b0}};
        end else begin
            vld1_r   <= in_vld;
            first1_r <= in_vld & in_first;
            last1_r  <= in_vld & in_last;
            if (in_vld) begin
                for (int i = 0; i < N_TAPS; i++)
                    prod_r[i] <= $signed(data_bus[i*DATA_W +: DATA_W]) *
                                 $signed(weight_bus[i*DATA_W +: DATA_W]);
                bias1_r <= bias;
            end
        end
    end

    // Balanced pairwise reduction; an odd leftover node is promoted unchanged.
    always_comb begin
        logic signed [TREE_W-1:0] node [2*N_TAPS];
        int cnt;
        for (int i = 0; i < 2*N_TAPS; i++) node[i] = {TREE_W{1'b0}};
        for (int i = 0; i < N_TAPS; i++) node[i] = TREE_W'(prod_r[i]);
        cnt = N_TAPS;
        for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < N_TAPS; j++) begin
                if (2*j + 1 < cnt)  node[j] = node[2*j] + node[2*j+1];
                else if (2*j < cnt) node[j] = node[2*j];
                else                node[j] = {TREE_W{1'b0}};
            end
            cnt = (cnt + 1) / 2;
        end
        tree_s = node[0];
    end

    // Stage 2: tree sum register with control and bias copies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tree_r   <= {TREE_W{1'b0}};
            vld2_r   <= 1'b0;
            first2_r <= 1'b0;
            last2_r  <= 1'b0;
            bias2_r  <= {ACC_W{1'b0}};
        end else begin
            vld2_r   <= vld1_r;
            first2_r <= first1_r;
            last2_r  <= last1_r;
            if (vld1_r) begin
                tree_r  <= tree_s;
                bias2_r <= bias1_r;
            end
        end
    end

    // Accumulate at one extra bit so overflow shows as a sign disagreement.
    always_comb begin
        base_s      = first2_r ? EXT_W'(bias2_r) : EXT_W'(acc_r);
        sum_s       = base_s + EXT_W'(tree_r);
        acc_clamp_s = 1'b0;
        if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
            acc_clamp_s = 1'b1;
            acc_next_s  = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next_s  = sum_s[ACC_W-1:0];
        end
        sticky_next_s = (first2_r ? 1'b0 : sticky_r) | acc_clamp_s;
    end

    // Requantise: shifts past the extended width collapse to the sign.
    always_comb begin
        rnd_s = {EXT_W{1'b0}};
        if (int'(shift) >= EXT_W) begin
            r_s = {EXT_W{acc_next_s[ACC_W-1]}};
        end else begin
            if (shift != {SHIFT_W{1'b0}}) rnd_s = RND_ONE << (shift - SHIFT_W'(1));
            else                          rnd_s = {EXT_W{1'b0}};
            r_s = (EXT_W'(acc_next_s) + rnd_s) >>> shift;
        end
        if (relu_en && r_s[EXT_W-1]) r_relu_s = {EXT_W{1'b0}};
        else                         r_relu_s = r_s;
        q_clamp_s = 1'b0;
        if (r_relu_s > Q_MAX) begin
            q_clamp_s = 1'b1;
            q_s       = Q_MAX_O;
        end else if (r_relu_s < Q_MIN) begin
            q_clamp_s = 1'b1;
            q_s       = Q_MIN_O;
        end else begin
            q_s       = r_relu_s[OUT_W-1:0];
        end
    end

    // Stage 3: accumulator, sticky overflow and registered group result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r     <= {ACC_W{1'b0}};
            sticky_r  <= 1'b0;
            out_vld_r <= 1'b0;
            ans_r     <= {ACC_W{1'b0}};
            q_out_r   <= {OUT_W{1'b0}};
            ovf_r     <= 1'b0;
        end else begin
            if (vld2_r) begin
                acc_r    <= acc_next_s;
                sticky_r <= sticky_next_s;
            end
            out_vld_r <= vld2_r & last2_r;
            if (vld2_r & last2_r) begin
                ans_r   <= acc_next_s;
                q_out_r <= q_s;
                ovf_r   <= sticky_next_s | q_clamp_s;
            end
        end
    end

    assign out_vld = out_vld_r;
    assign ans     = ans_r;
    assign q_out   = q_out_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_inner_dot_acc_pipe.sv
// Scoreboard bench for inner_dot_acc_pipe: a reference model queues expected group
// results (value and arrival cycle) as beats are driven; a monitor pops and compares.
module tb_inner_dot_acc_pipe;

    localparam int N  = 9;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int OW = 8;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_vld, in_first, in_last;
    logic [N*DW-1:0]   data_bus, weight_bus;
    logic [AW-1:0]     bias;
    logic [SW-1:0]     shift;
    logic              relu_en;
    logic              out_vld;
    logic [AW-1:0]     ans;
    logic [OW-1:0]     q_out;
    logic              ovf;

    inner_dot_acc_pipe #(.N_TAPS(N), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .SHIFT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_first(in_first), .in_last(in_last),
        .data_bus(data_bus), .weight_bus(weight_bus), .bias(bias), .shift(shift),
        .relu_en(relu_en), .out_vld(out_vld), .ans(ans), .q_out(q_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        longint ans;
        longint q;
        bit     ovf;
        int     cyc;
    } exp_t;
    exp_t sb[$];

    int     da [N];
    int     wa [N];
    longint m_acc    = 0;
    bit     m_sticky = 1'b0;

    function automatic longint sat(input longint v, input int w, output bit c);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        c = 1'b0;
        if (v > hi) begin c = 1'b1; return hi; end
        if (v < lo) begin c = 1'b1; return lo; end
        return v;
    endfunction

    task automatic fill(input int dv, input int wv, input bit ramp);
        for (int i = 0; i < N; i++) begin
            da[i] = dv;
            wa[i] = ramp ? i + 1 : wv;
        end
    endtask

    task automatic drive_beat(input bit f, input bit l, input longint b);
        longint tree, base, r;
        bit c1, c2;
        exp_t e;
        @(negedge clk);
        in_vld = 1'b1; in_first = f; in_last = l; bias = AW'(b);
        tree = 0;
        for (int i = 0; i < N; i++) begin
            data_bus[i*DW +: DW]   = DW'(da[i]);
            weight_bus[i*DW +: DW] = DW'(wa[i]);
            tree += longint'(da[i]) * longint'(wa[i]);
        end
        base     = f ? b : m_acc;
        m_acc    = sat(base + tree, AW, c1);
        m_sticky = (f ? 1'b0 : m_sticky) | c1;
        if (l) begin
            if (int'(shift) >= AW + 1) r = (m_acc < 0) ? -1 : 0;
            else if (shift == 0)       r = m_acc;
            else                       r = (m_acc + (longint'(1) << (int'(shift) - 1))) >>> int'(shift);
            if (relu_en && r < 0) r = 0;
            e.q   = sat(r, OW, c2);
            e.ans = m_acc;
            e.ovf = m_sticky | c2;
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_vld = 1'b0; in_first = 1'($urandom); in_last = 1'($urandom);
            data_bus = {N*DW{1'b1}}; weight_bus = {N*DW{1'b1}}; bias = AW'($urandom);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        idle(1);
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every out_vld pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (out_vld === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out_vld: cycle %0d ans %0d, required no pulse", cyc, $signed(ans));
            end else begin
                n_err--;
                e = sb.pop_front();
                n_err++;
                if (cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL latency: out_vld at cycle %0d, required %0d", cyc, e.cyc);
                end
                n_cmp++;
                if (longint'($signed(ans)) !== e.ans) begin
                    n_err++;
                    $display("FAIL ans: got %0d required %0d", $signed(ans), e.ans);
                end
                n_cmp++;
                if (longint'($signed(q_out)) !== e.q) begin
                    n_err++;
                    $display("FAIL q_out: got %0d required %0d", $signed(q_out), e.q);
                end
                n_cmp++;
                if (ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL ovf: got %0b required %0b", ovf, e.ovf);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            in_vld = 1'b1; in_first = 1'b1; in_last = 1'b1;
            data_bus = N*DW'($urandom); weight_bus = N*DW'($urandom); bias = AW'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1; in_vld = 1'b0;
        m_acc = 0; m_sticky = 1'b0; sb.delete();
        n_cmp++;
        if ({out_vld, ans, q_out, ovf} !== {1'b0, {AW{1'b0}}, {OW{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: vld %0b ans %0d q %0d ovf %0b, required all 0", out_vld, ans, q_out, ovf);
        end
        idle(6);
    endtask

    task automatic test_single();
        shift = 5'd0; relu_en = 1'b0;
        fill(1, 0, 1'b1);
        drive_beat(1'b1, 1'b1, 10);
        drain();
    endtask

    task automatic test_multi_bubbles();
        fill(2, 3, 1'b0);
        drive_beat(1'b1, 1'b0, -100);
        idle(1);
        drive_beat(1'b0, 1'b0, 0);
        drive_beat(1'b0, 1'b1, 0);
        drain();
        relu_en = 1'b1;
        drive_beat(1'b1, 1'b0, -200);
        idle(1);
        drive_beat(1'b0, 1'b0, 0);
        drive_beat(1'b0, 1'b1, 0);
        drain();
        relu_en = 1'b0;
    endtask

    task automatic test_extremes();
        shift = 5'd10;
        fill(-128, -128, 1'b0);
        drive_beat(1'b1, 1'b1, 0);
        drain();
        shift = 5'd0;
        fill(1, 1, 1'b0);
        drive_beat(1'b1, 1'b1, 0);
        drain();
    endtask

    task automatic test_acc_saturation();
        fill(-128, -128, 1'b0);
        for (int i = 0; i < 57; i++) drive_beat(i == 0, i == 56, 0);
        drain();
    endtask

    task automatic test_reset_mid_group();
        fill(1, 0, 1'b1);
        drive_beat(1'b1, 1'b0, 10);
        @(negedge clk);
        rst_n = 1'b0; in_vld = 1'b0;
        m_acc = 0; m_sticky = 1'b0; sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_beat(1'b0, 1'b1, 999);
        drain();
    endtask

    task automatic test_restart_and_orphan();
        fill(1, 0, 1'b1);
        drive_beat(1'b1, 1'b0, 10);
        fill(1, 1, 1'b0);
        drive_beat(1'b1, 1'b1, 7);
        fill(-3, 5, 1'b0);
        drive_beat(1'b0, 1'b1, 12345);
        drain();
    endtask

    task automatic test_back_to_back();
        shift = 5'd3; relu_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) begin
                da[i] = int'($urandom_range(0, 255)) - 128;
                wa[i] = int'($urandom_range(0, 255)) - 128;
            end
            drive_beat(1'b1, 1'b1, longint'($urandom_range(0, 4000)) - 2000);
        end
        drain();
        relu_en = 1'b0;
    endtask

    task automatic test_big_shift();
        shift = 5'd26;
        fill(0, 0, 1'b0);
        drive_beat(1'b1, 1'b1, -5);
        drive_beat(1'b1, 1'b1, 1000);
        drain();
        shift = 5'd24;
        fill(-128, -128, 1'b0);
        drive_beat(1'b1, 1'b1, 8000000);
        drain();
        shift = 5'd0;
    endtask

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_first = 1'b0; in_last = 1'b0;
        data_bus = {N*DW{1'b0}}; weight_bus = {N*DW{1'b0}}; bias = {AW{1'b0}};
        shift = 5'd0; relu_en = 1'b0;
        test_reset();
        test_single();
        test_multi_bubbles();
        test_extremes();
        test_acc_saturation();
        test_reset_mid_group();
        test_restart_and_orphan();
        test_back_to_back();
        test_big_shift();
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
